// File: rtl/stream_pkg.sv
// Shared definitions for the stream width converters (packer and downsizer).
package stream_pkg;

  typedef enum logic {IDLE, SEND} dsz_state_t;

  // Widest lane mask the helper function accepts.
  localparam int unsigned MaxRatio = 32;

  // True when the mask has at most one bit set.
  function automatic logic onehot0_le1(input logic [MaxRatio-1:0] mask);
    return (mask & (mask - MaxRatio'(1))) == '0;
  endfunction

endpackage

// File: rtl/stream_lane_pick.sv
// Lowest-set-bit priority encoder over a lane mask; flags masks holding exactly one lane.
module stream_lane_pick
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_RATIO = 2,
  localparam int unsigned IdxW = $clog2(T_DATA_RATIO)
) (
  input  logic [T_DATA_RATIO-1:0] mask,
  output logic [IdxW-1:0]         idx,
  output logic                    last_one
);

  always_comb begin
    idx = '0;
    // Walk downwards so the lowest set bit is the one that sticks.
    for (int i = int'(T_DATA_RATIO) - 1; i >= 0; i--) begin
      if (mask[i]) idx = IdxW'(i);
    end
    last_one = (mask != '0) && onehot0_le1(MaxRatio'(mask));
  end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: serializes the kept lanes of each wide beat, lane 0 first.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 4,
  parameter int unsigned T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int unsigned IdxW = $clog2(T_DATA_RATIO);

  dsz_state_t              state_q, state_d;
  logic [T_DATA_WIDTH-1:0] lane_buf_q [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] rem_q, rem_d;
  logic                    pkt_last_q, pkt_last_d;
  logic                    load;
  logic                    accept;
  logic [T_DATA_RATIO-1:0] cur_bit;
  logic [IdxW-1:0]         cur;
  logic                    last_one;

  stream_lane_pick #(
    .T_DATA_RATIO(T_DATA_RATIO)
  ) u_pick (
    .mask    (rem_q),
    .idx     (cur),
    .last_one(last_one)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    pkt_last_d = pkt_last_q;
    load       = 1'b0;
    s_ready_o  = 1'b0;
    cur_bit    = '0;
    cur_bit[cur] = 1'b1;

    unique case (state_q)
      IDLE:    s_ready_o = !rst;
      // A new beat may enter only while the final lane of the current one leaves.
      SEND:    s_ready_o = !rst && m_ready_i && last_one;
      default: s_ready_o = 1'b0;
    endcase

    accept = s_valid_i && s_ready_o;

    if (state_q == SEND && m_ready_i) begin
      rem_d = rem_q & ~cur_bit;
      if (rem_d == '0) state_d = IDLE;
    end

    // Empty-keep beats are consumed without touching the lane state.
    if (accept && (s_keep_i != '0)) begin
      load       = 1'b1;
      rem_d      = s_keep_i;
      pkt_last_d = s_last_i;
      state_d    = SEND;
    end
  end

  always_comb begin
    m_valid_o = (state_q == SEND);
    m_data_o  = m_valid_o ? lane_buf_q[cur] : '0;
    m_last_o  = m_valid_o && pkt_last_q && last_one;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      pkt_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      pkt_last_q <= pkt_last_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(T_DATA_RATIO); i++) lane_buf_q[i] <= '0;
    end else if (load) begin
      lane_buf_q <= s_data_i;
    end
  end

endmodule
